// File: rtl/sprite_motion_ctrl.sv
// Per-frame motion sequencer for the ball (20x20) and paddle (120x40) sprites.
// Each accepted frame tick runs PADDLE then BALL update phases, then signals completion.
module sprite_motion_ctrl #(
  parameter int unsigned PADDLE_Y     = 440,
  parameter int unsigned PADDLE_SPEED = 8,
  parameter int unsigned BALL_SPEED   = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       FRAME_TICK,
  input  logic       ENABLE,
  input  logic       BTN_LEFT,
  input  logic       BTN_RIGHT,
  input  logic       LAUNCH,
  input  logic       REFLECT_X,
  input  logic       REFLECT_Y,
  output logic [9:0] PADDLE_X,
  output logic [8:0] PADDLE_Y_OUT,
  output logic [9:0] BALL_X,
  output logic [8:0] BALL_Y,
  output logic       BALL_MOVING,
  output logic       LIFE_LOST,
  output logic       UPDATE_DONE
);

  localparam logic [10:0] PY        = 11'(PADDLE_Y);
  localparam logic [10:0] PS        = 11'(PADDLE_SPEED);
  localparam logic [10:0] BS        = 11'(BALL_SPEED);
  localparam logic [10:0] BALL_SZ   = 11'd20;
  localparam logic [10:0] PAD_W     = 11'd120;
  localparam logic [10:0] PAD_MAX   = 11'd520;
  localparam logic [10:0] BALL_XMAX = 11'd620;
  localparam logic [10:0] Y_LOST    = 11'd460;
  localparam logic [10:0] SERVE_OFS = 11'd50;
  localparam logic [9:0]  PADDLE_X_RST = 10'd260;
  localparam logic [9:0]  BALL_X_RST   = 10'(PADDLE_X_RST + SERVE_OFS);
  localparam logic [8:0]  BALL_Y_REST  = 9'(PY - BALL_SZ);

  typedef enum logic [1:0] {IDLE, PADDLE, BALL, DONE} phase_t;

  phase_t     state, state_nx;
  logic       dx_right, dy_up, dx_nx, dy_nx;
  logic       launch_f, rx_f, ry_f;
  logic       launch_nx, rx_nx, ry_nx;
  logic [9:0] paddle_x_nx, ball_x_nx;
  logic [8:0] ball_y_nx;
  logic       moving_nx, life_lost_nx, update_done_nx;
  logic       wall_x, wall_y, hit;
  logic [10:0] px, bx, by;

  assign PADDLE_Y_OUT = 9'(PADDLE_Y);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      PADDLE_X    <= PADDLE_X_RST;
      BALL_X      <= BALL_X_RST;
      BALL_Y      <= BALL_Y_REST;
      BALL_MOVING <= 1'b0;
      dx_right    <= 1'b1;
      dy_up       <= 1'b1;
      launch_f    <= 1'b0;
      rx_f        <= 1'b0;
      ry_f        <= 1'b0;
      LIFE_LOST   <= 1'b0;
      UPDATE_DONE <= 1'b0;
    end else begin
      state       <= state_nx;
      PADDLE_X    <= paddle_x_nx;
      BALL_X      <= ball_x_nx;
      BALL_Y      <= ball_y_nx;
      BALL_MOVING <= moving_nx;
      dx_right    <= dx_nx;
      dy_up       <= dy_nx;
      launch_f    <= launch_nx;
      rx_f        <= rx_nx;
      ry_f        <= ry_nx;
      LIFE_LOST   <= life_lost_nx;
      UPDATE_DONE <= update_done_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    paddle_x_nx    = PADDLE_X;
    ball_x_nx      = BALL_X;
    ball_y_nx      = BALL_Y;
    moving_nx      = BALL_MOVING;
    dx_nx          = dx_right;
    dy_nx          = dy_up;
    launch_nx      = launch_f | LAUNCH;
    rx_nx          = rx_f | REFLECT_X;
    ry_nx          = ry_f | REFLECT_Y;
    life_lost_nx   = 1'b0;
    update_done_nx = 1'b0;
    wall_x         = 1'b0;
    wall_y         = 1'b0;
    hit            = 1'b0;
    px             = {1'b0, PADDLE_X};
    bx             = {1'b0, BALL_X};
    by             = {2'b00, BALL_Y};

    case (state)
      IDLE: begin
        if (FRAME_TICK && ENABLE) state_nx = PADDLE;
      end
      PADDLE: begin
        state_nx = BALL;
        if (BTN_LEFT && !BTN_RIGHT) begin
          paddle_x_nx = (px < PS) ? '0 : 10'(px - PS);
        end else if (BTN_RIGHT && !BTN_LEFT) begin
          paddle_x_nx = (px + PS >= PAD_MAX) ? 10'(PAD_MAX) : 10'(px + PS);
        end
      end
      BALL: begin
        state_nx = DONE;
        // Only pulses arriving this cycle survive the consume.
        launch_nx = LAUNCH;
        rx_nx     = REFLECT_X;
        ry_nx     = REFLECT_Y;
        if (!BALL_MOVING) begin
          ball_x_nx = 10'(px + SERVE_OFS);
          ball_y_nx = BALL_Y_REST;
          if (launch_f) begin
            moving_nx = 1'b1;
            dx_nx     = 1'b1;
            dy_nx     = 1'b1;
          end
        end else begin
          if (dx_right) begin
            if (bx + BS >= BALL_XMAX) begin
              ball_x_nx = 10'(BALL_XMAX);
              wall_x    = 1'b1;
            end else begin
              ball_x_nx = 10'(bx + BS);
            end
          end else if (bx < BS) begin
            ball_x_nx = '0;
            wall_x    = 1'b1;
          end else begin
            ball_x_nx = 10'(bx - BS);
          end

          if (dy_up) begin
            if (by < BS) begin
              ball_y_nx = '0;
              wall_y    = 1'b1;
            end else begin
              ball_y_nx = 9'(by - BS);
            end
          end else begin
            hit = (by + BALL_SZ <= PY) && (by + BS + BALL_SZ >= PY) &&
                  (bx + BALL_SZ > px) && (bx < px + PAD_W);
            if (hit) begin
              ball_y_nx = BALL_Y_REST;
              wall_y    = 1'b1;
            end else begin
              ball_y_nx = 9'(by + BS);
              if (by + BS >= Y_LOST) begin
                life_lost_nx = 1'b1;
                moving_nx    = 1'b0;
              end
            end
          end

          // Any flip source inverts once; walls/paddle and block flags never stack.
          dx_nx = (wall_x || rx_f) ? ~dx_right : dx_right;
          dy_nx = (wall_y || ry_f) ? ~dy_up : dy_up;
        end
      end
      DONE: begin
        state_nx       = IDLE;
        update_done_nx = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Self-checking bench for sprite_motion_ctrl: frame-level behavioural model,
// per-cycle output comparison, directed scenarios and randomized stimulus.
module tb_sprite_motion_ctrl;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       FRAME_TICK, ENABLE, BTN_LEFT, BTN_RIGHT, LAUNCH, REFLECT_X, REFLECT_Y;
  logic [9:0] PADDLE_X, BALL_X;
  logic [8:0] PADDLE_Y_OUT, BALL_Y;
  logic       BALL_MOVING, LIFE_LOST, UPDATE_DONE;

  int checks = 0;
  int errors = 0;

  sprite_motion_ctrl #(.PADDLE_Y(440), .PADDLE_SPEED(8), .BALL_SPEED(4)) dut (
    .CLK(CLK), .RESET(RESET), .FRAME_TICK(FRAME_TICK), .ENABLE(ENABLE),
    .BTN_LEFT(BTN_LEFT), .BTN_RIGHT(BTN_RIGHT), .LAUNCH(LAUNCH),
    .REFLECT_X(REFLECT_X), .REFLECT_Y(REFLECT_Y),
    .PADDLE_X(PADDLE_X), .PADDLE_Y_OUT(PADDLE_Y_OUT), .BALL_X(BALL_X), .BALL_Y(BALL_Y),
    .BALL_MOVING(BALL_MOVING), .LIFE_LOST(LIFE_LOST), .UPDATE_DONE(UPDATE_DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: signed positions and velocities, frame phase counter.
  int mpx = 260, mbx = 310, mby = 420, mvx = 4, mvy = -4, mph = 0;
  bit mmov = 0, mlf = 0, mrx = 0, mry = 0, mll = 0, mud = 0;
  int nx, ny, old_ph;
  bit fx, fy;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mpx = 260; mbx = 310; mby = 420; mvx = 4; mvy = -4; mph = 0;
      mmov = 0; mlf = 0; mrx = 0; mry = 0; mll = 0; mud = 0;
    end else begin
      mll = 0;
      mud = 0;
      old_ph = mph;
      case (mph)
        0: if (FRAME_TICK && ENABLE) mph = 1;
        1: begin
          if (BTN_LEFT && !BTN_RIGHT) mpx = (mpx - 8 < 0) ? 0 : mpx - 8;
          else if (BTN_RIGHT && !BTN_LEFT) mpx = (mpx + 8 > 520) ? 520 : mpx + 8;
          mph = 2;
        end
        2: begin
          if (!mmov) begin
            mbx = mpx + 50;
            mby = 420;
            if (mlf) begin mmov = 1; mvx = 4; mvy = -4; end
          end else begin
            nx = mbx + mvx; fx = 0;
            if (nx < 0) begin nx = 0; fx = 1; end
            else if (nx >= 620) begin nx = 620; fx = 1; end
            ny = mby + mvy; fy = 0;
            if (mvy < 0) begin
              if (ny < 0) begin ny = 0; fy = 1; end
            end else if (mby + 20 <= 440 && ny + 20 >= 440 && mbx + 20 > mpx && mbx < mpx + 120) begin
              ny = 420; fy = 1;
            end else if (ny >= 460) begin
              mll = 1; mmov = 0;
            end
            if (fx || mrx) mvx = -mvx;
            if (fy || mry) mvy = -mvy;
            mbx = nx;
            mby = ny;
          end
          mph = 3;
        end
        default: begin mud = 1; mph = 0; end
      endcase
      if (old_ph == 2) begin
        mlf = LAUNCH; mrx = REFLECT_X; mry = REFLECT_Y;
      end else begin
        mlf = mlf | LAUNCH; mrx = mrx | REFLECT_X; mry = mry | REFLECT_Y;
      end
    end
  end

  always @(negedge CLK) begin
    chk("paddle_x", PADDLE_X, mpx);
    chk("paddle_y_out", PADDLE_Y_OUT, 440);
    chk("ball_x", BALL_X, mbx);
    chk("ball_y", BALL_Y, mby);
    chk("ball_moving", BALL_MOVING, mmov);
    chk("life_lost", LIFE_LOST, mll);
    chk("update_done", UPDATE_DONE, mud);
  end

  task automatic step();
    @(negedge CLK);
    #2;
  endtask

  task automatic frame();
    FRAME_TICK = 1'b1;
    step();
    FRAME_TICK = 1'b0;
    step();
    step();
    chk("done_not_early", UPDATE_DONE, 0);
    step();
    chk("done_at_3", UPDATE_DONE, 1);
  endtask

  initial begin
    RESET = 1'b0; FRAME_TICK = 0; ENABLE = 1; BTN_LEFT = 0; BTN_RIGHT = 0;
    LAUNCH = 0; REFLECT_X = 0; REFLECT_Y = 0;
    repeat (3) step();
    chk("rst_paddle_x", PADDLE_X, 260);
    chk("rst_ball_x", BALL_X, 310);
    chk("rst_ball_y", BALL_Y, 420);
    chk("rst_moving", BALL_MOVING, 0);
    chk("rst_done", UPDATE_DONE, 0);
    RESET = 1'b1;
    step();

    // Serve then first play frame
    LAUNCH = 1; step(); LAUNCH = 0;
    frame();
    chk("launch_moving", BALL_MOVING, 1);
    chk("launch_x", BALL_X, 310);
    chk("launch_y", BALL_Y, 420);
    frame();
    chk("play1_x", BALL_X, 314);
    chk("play1_y", BALL_Y, 416);
    chk("model_play1_x", mbx, 314);
    chk("model_play1_y", mby, 416);

    // Right wall with a simultaneous block reflect: single flip
    repeat (76) frame();
    chk("pre_wall_x", BALL_X, 618);
    chk("pre_wall_y", BALL_Y, 112);
    REFLECT_X = 1; step(); REFLECT_X = 0;
    frame();
    chk("wall_x", BALL_X, 620);
    frame();
    chk("wall_back_x", BALL_X, 616);
    chk("wall_back_y", BALL_Y, 104);
    chk("model_wall_back_x", mbx, 616);
    frame();
    REFLECT_Y = 1; step(); REFLECT_Y = 0;
    frame();
    chk("refy_y0", BALL_Y, 96);
    frame();
    chk("refy_y1", BALL_Y, 100);
    chk("refy_x1", BALL_X, 604);

    // Paddle clamps
    BTN_LEFT = 1;
    repeat (32) frame();
    chk("paddle_4", PADDLE_X, 4);
    frame();
    chk("paddle_0", PADDLE_X, 0);
    BTN_RIGHT = 1;
    frame();
    chk("paddle_both", PADDLE_X, 0);
    BTN_LEFT = 0;
    repeat (64) frame();
    chk("paddle_512", PADDLE_X, 512);
    frame();
    chk("paddle_520", PADDLE_X, 520);
    frame();
    chk("paddle_clamp", PADDLE_X, 520);
    BTN_RIGHT = 0;

    // Disabled tick is ignored
    ENABLE = 0; BTN_LEFT = 1;
    FRAME_TICK = 1; step(); FRAME_TICK = 0;
    repeat (4) begin step(); chk("disabled_done", UPDATE_DONE, 0); end
    chk("disabled_paddle", PADDLE_X, 520);
    ENABLE = 1; BTN_LEFT = 0;

    // Tick held into the PADDLE phase gives one frame only
    FRAME_TICK = 1; step(); step(); FRAME_TICK = 0;
    step(); step();
    chk("held_tick_done", UPDATE_DONE, 1);
    step(); chk("held_tick_once_a", UPDATE_DONE, 0);
    step(); chk("held_tick_once_b", UPDATE_DONE, 0);

    // Reset during the BALL phase
    BTN_RIGHT = 1;
    FRAME_TICK = 1; step(); FRAME_TICK = 0; step();
    BTN_RIGHT = 0;
    RESET = 0; #1;
    chk("midreset_paddle", PADDLE_X, 260);
    chk("midreset_ball_x", BALL_X, 310);
    chk("midreset_ball_y", BALL_Y, 420);
    chk("midreset_moving", BALL_MOVING, 0);
    step(); RESET = 1; step();

    // Randomized play
    for (int i = 0; i < 20000; i++) begin
      step();
      RESET      = ($urandom % 2500) != 0;
      FRAME_TICK = ($urandom % 4) == 0;
      ENABLE     = ($urandom % 16) != 0;
      if ($urandom % 8 == 0) BTN_LEFT = ~BTN_LEFT;
      if ($urandom % 8 == 0) BTN_RIGHT = ~BTN_RIGHT;
      LAUNCH     = ($urandom % 24) == 0;
      REFLECT_X  = ($urandom % 40) == 0;
      REFLECT_Y  = ($urandom % 40) == 0;
    end
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
